// File: rtl/acpi_pass_sched.sv
// rtl/acpi_pass_sched.sv - two-pass frame sequencer for the ACPI demosaic core
// Drives core soft reset, data-ready and pass select, counts write strobes, guards each pass with a watchdog.
module acpi_pass_sched #(
  parameter int RST_CYC  = 2,
  parameter int WD_W     = 20,
  parameter int WD_LIMIT = 200000,
  parameter int CNT_W    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             core_finish,
  input  logic             core_finish_rb,
  input  logic             green_valid,
  input  logic             blue_valid,
  input  logic             red_valid,
  output logic             core_rst,
  output logic             bayer_ready,
  output logic             pass_sel,
  output logic             busy,
  output logic             frame_done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] g_wr_cnt,
  output logic [CNT_W-1:0] rb_wr_cnt,
  output logic [2:0]       state
);

  localparam int C_W = (RST_CYC < 1) ? 1 : $clog2(RST_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_P1_RST = 3'd1,
    S_P1_RUN = 3'd2,
    S_P2_RST = 3'd3,
    S_P2_RUN = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t          cur, nxt;
  logic [C_W-1:0]  c, c_n;
  logic [WD_W-1:0] wd, wd_n;
  logic            clr_cnt;
  logic            any_valid;
  logic            g_inc, rb_inc;

  assign any_valid = green_valid | blue_valid | red_valid;
  assign g_inc     = (cur == S_P1_RUN) && green_valid && (g_wr_cnt != '1);
  assign rb_inc    = (cur == S_P2_RUN) && (blue_valid || red_valid) && (rb_wr_cnt != '1);
  assign state     = cur;

  always_comb begin
    nxt     = cur;
    c_n     = c;
    wd_n    = wd;
    clr_cnt = 1'b0;
    case (cur)
      S_IDLE, S_ERR: begin
        if (start) begin
          nxt     = S_P1_RST;
          c_n     = '0;
          clr_cnt = 1'b1;
        end
      end
      S_P1_RST, S_P2_RST: begin
        if (c == C_W'(RST_CYC)) begin
          nxt  = (cur == S_P1_RST) ? S_P1_RUN : S_P2_RUN;
          wd_n = '0;
        end else begin
          c_n = c + 1'b1;
        end
      end
      S_P1_RUN, S_P2_RUN: begin
        // The finish flag is tested before the watchdog so it wins a same-cycle race.
        if ((cur == S_P1_RUN) ? core_finish : core_finish_rb) begin
          nxt = (cur == S_P1_RUN) ? S_P2_RST : S_DONE;
          c_n = '0;
        end else if (any_valid) begin
          wd_n = '0;
        end else if (wd == WD_W'(WD_LIMIT - 1)) begin
          nxt = S_ERR;
        end else begin
          wd_n = wd + 1'b1;
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they sit in flops aligned with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur         <= S_IDLE;
      c           <= '0;
      wd          <= '0;
      g_wr_cnt    <= '0;
      rb_wr_cnt   <= '0;
      core_rst    <= 1'b0;
      bayer_ready <= 1'b0;
      pass_sel    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cur <= nxt;
      c   <= c_n;
      wd  <= wd_n;
      if (clr_cnt) begin
        g_wr_cnt  <= '0;
        rb_wr_cnt <= '0;
      end else begin
        if (g_inc)  g_wr_cnt  <= g_wr_cnt + 1'b1;
        if (rb_inc) rb_wr_cnt <= rb_wr_cnt + 1'b1;
      end
      core_rst    <= (((nxt == S_P1_RST) || (nxt == S_P2_RST)) && (c_n < C_W'(RST_CYC)))
                     || (nxt == S_ERR);
      bayer_ready <= (nxt == S_P1_RUN) || (nxt == S_P2_RUN);
      pass_sel    <= (nxt == S_P2_RST) || (nxt == S_P2_RUN) || (nxt == S_DONE);
      busy        <= (nxt != S_IDLE) && (nxt != S_ERR);
      frame_done  <= (nxt == S_DONE);
      timeout_err <= (nxt == S_ERR);
    end
  end

endmodule

// File: tb/tb_acpi_pass_sched.sv
// tb/tb_acpi_pass_sched.sv - vector table, corner sequences and random run against a reference model
module tb_acpi_pass_sched;
  localparam int RST_CYC = 2, WD_LIMIT = 16, CNT_W = 4;
  localparam int SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b0;
  logic start = 1'b0, core_finish = 1'b0, core_finish_rb = 1'b0;
  logic green_valid = 1'b0, blue_valid = 1'b0, red_valid = 1'b0;
  logic core_rst, bayer_ready, pass_sel, busy, frame_done, timeout_err;
  logic [CNT_W-1:0] g_wr_cnt, rb_wr_cnt;
  logic [2:0] state;

  int n_vec = 0, n_err = 0;
  int m_s = 0, m_t = 0, m_idle = 0, m_g = 0, m_rb = 0;
  bit m_terr = 0;

  always #5 clk = ~clk;

  acpi_pass_sched #(.RST_CYC(RST_CYC), .WD_W(8), .WD_LIMIT(WD_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .core_finish(core_finish),
    .core_finish_rb(core_finish_rb), .green_valid(green_valid), .blue_valid(blue_valid),
    .red_valid(red_valid), .core_rst(core_rst), .bayer_ready(bayer_ready), .pass_sel(pass_sel),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err), .g_wr_cnt(g_wr_cnt),
    .rb_wr_cnt(rb_wr_cnt), .state(state));

  typedef struct {
    logic [5:0] in;   // start, finish, finish_rb, green, blue, red
    logic [2:0] st;
    logic [5:0] fl;   // core_rst, bayer_ready, pass_sel, busy, frame_done, timeout_err
    int         g;
    int         rb;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_vec();
    return {state, core_rst, bayer_ready, pass_sel, busy, frame_done, timeout_err,
            g_wr_cnt, rb_wr_cnt};
  endfunction

  function automatic int model_vec();
    logic [5:0] f;
    f[5] = ((m_s == 1 || m_s == 3) && m_t < RST_CYC) || m_s == 6;
    f[4] = (m_s == 2 || m_s == 4);
    f[3] = (m_s >= 3 && m_s <= 5);
    f[2] = !(m_s == 0 || m_s == 6);
    f[1] = (m_s == 5);
    f[0] = m_terr;
    return {m_s[2:0], f, m_g[3:0], m_rb[3:0]};
  endfunction

  task automatic model_step(input bit st, fin, finrb, gv, bv, rv);
    bit done;
    case (m_s)
      0, 6: if (st) begin m_s = 1; m_t = 0; m_g = 0; m_rb = 0; m_terr = 0; end
      1, 3: if (m_t == RST_CYC) begin m_s++; m_t = 0; m_idle = 0; end else m_t++;
      2, 4: begin
        if (m_s == 2 && gv) m_g = (m_g < SAT) ? m_g + 1 : SAT;
        if (m_s == 4 && (bv || rv)) m_rb = (m_rb < SAT) ? m_rb + 1 : SAT;
        done = (m_s == 2) ? fin : finrb;
        if (done) begin m_s++; m_t = 0; end
        else if (gv || bv || rv) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == WD_LIMIT) begin m_s = 6; m_terr = 1; end
        end
      end
      5: m_s = 0;
      default: m_s = 0;
    endcase
  endtask

  task automatic cycle(input bit st, fin, finrb, gv, bv, rv);
    start = st; core_finish = fin; core_finish_rb = finrb;
    green_valid = gv; blue_valid = bv; red_valid = rv;
    @(posedge clk);
    model_step(st, fin, finrb, gv, bv, rv);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tbl[0]  = '{6'b100000, 3'd1, 6'b100100, 0, 0};
    tbl[1]  = '{6'b000000, 3'd1, 6'b100100, 0, 0};
    tbl[2]  = '{6'b000000, 3'd1, 6'b000100, 0, 0};
    tbl[3]  = '{6'b000000, 3'd2, 6'b010100, 0, 0};
    tbl[4]  = '{6'b000100, 3'd2, 6'b010100, 1, 0};
    tbl[5]  = '{6'b001100, 3'd2, 6'b010100, 2, 0};
    tbl[6]  = '{6'b010000, 3'd3, 6'b101100, 2, 0};
    tbl[7]  = '{6'b000000, 3'd3, 6'b101100, 2, 0};
    tbl[8]  = '{6'b000000, 3'd3, 6'b001100, 2, 0};
    tbl[9]  = '{6'b000000, 3'd4, 6'b011100, 2, 0};
    tbl[10] = '{6'b010010, 3'd4, 6'b011100, 2, 1};
    tbl[11] = '{6'b100001, 3'd4, 6'b011100, 2, 2};
    tbl[12] = '{6'b001000, 3'd5, 6'b001110, 2, 2};
    tbl[13] = '{6'b000000, 3'd0, 6'b000000, 2, 2};

    repeat (3) @(posedge clk);
    #1 check("reset_state", dut_vec(), 0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].in[5], tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      check($sformatf("tbl%0d", i), {state, core_rst, bayer_ready, pass_sel, busy, frame_done,
            timeout_err, g_wr_cnt, rb_wr_cnt}, {tbl[i].st, tbl[i].fl, tbl[i].g[3:0], tbl[i].rb[3:0]});
    end

    // Watchdog: ERR after exactly WD_LIMIT idle cycles in P1_RUN
    cycle(1, 0, 0, 0, 0, 0); idle(3);
    check("p1_run_entry", state, 2);
    idle(WD_LIMIT - 1);
    check("wd_not_yet", state, 2);
    idle(1);
    check("wd_err_state", state, 6);
    check("wd_err_flags", {core_rst, bayer_ready, busy, timeout_err}, 4'b1001);
    cycle(1, 0, 0, 0, 0, 0);
    check("err_restart", {state, timeout_err}, {3'd1, 1'b0});

    // Race: finish on the watchdog's final cycle
    idle(3); idle(WD_LIMIT - 1);
    cycle(0, 1, 0, 0, 0, 0);
    check("race_finish_wins", {state, timeout_err, pass_sel}, {3'd3, 1'b0, 1'b1});

    // Busy start ignored, rb counter saturation, finish ignored in P2_RUN
    idle(3);
    for (int i = 0; i < 20; i++) cycle(i[0], i[1], 0, 0, 1, i[2]);
    check("rb_saturate", {state, rb_wr_cnt}, {3'd4, 4'd15});
    cycle(0, 0, 1, 0, 0, 0);
    check("frame_done", {state, frame_done}, {3'd5, 1'b1});
    idle(1);
    check("back_idle", {state, frame_done, pass_sel}, {3'd0, 1'b0, 1'b0});

    // g counter saturation, then async reset mid-P2_RUN
    cycle(1, 0, 0, 0, 0, 0); idle(3);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 1, 0, 0);
    check("g_saturate", {state, g_wr_cnt}, {3'd2, 4'd15});
    cycle(0, 1, 0, 0, 0, 0); idle(3);
    cycle(0, 0, 0, 0, 1, 0);
    #2 rst = 1'b0;
    #1 check("async_rst", {state, core_rst, bayer_ready, pass_sel, busy}, 0);
    m_s = 0; m_t = 0; m_idle = 0; m_g = 0; m_rb = 0; m_terr = 0;
    @(negedge clk) rst = 1'b1;

    // Random traffic with quiet stretches to reach the watchdog
    for (int blk = 0; blk < 60; blk++) begin
      bit quiet;
      quiet = ($urandom_range(3) == 0);
      for (int i = 0; i < 50; i++) begin
        cycle($urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(15) == 0,
              !quiet && $urandom_range(2) == 0, !quiet && $urandom_range(2) == 0,
              !quiet && $urandom_range(2) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
